// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register-number width,
// default mult/div occupancies and the mult/div scheduler state encoding.
package pipe_pkg;

  localparam int REG_W          = 5;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 12;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Per-cycle hazard decisions made in ID.
  typedef struct packed {
    logic lu;
    logic md_haz;
    logic stall;
  } hazard_t;

endpackage

// File: rtl/hazard_ctrl_md_sched.sv
// Shared multiply/divide unit scheduler: an IDLE/BUSY FSM with a down-counter
// loaded with the selected occupancy when an operation issues.
module md_sched
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Occupancies must fit the counter and leave room for a distinct done cycle.
  if (MUL_CYCLES < 2 || MUL_CYCLES > (1 << CNT_W) - 1) begin : g_bad_mul
    $error("md_sched: MUL_CYCLES out of range for CNT_W");
  end
  if (DIV_CYCLES < 2 || DIV_CYCLES > (1 << CNT_W) - 1) begin : g_bad_div
    $error("md_sched: DIV_CYCLES out of range for CNT_W");
  end

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (issue) begin
          cnt_d   = is_div ? DIV_LD : MUL_LD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (cnt_q == CNT_ONE) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = MD_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS core: branch squash,
// load-use stalls and mult/div scheduling (scheduler built when HAZARD_CTRL_MD_EN is defined).
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs_D,
  input  logic [REG_W-1:0] Rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             RegWr_E,
  input  logic             MemtoReg_E,
  input  logic [REG_W-1:0] RegWrDst_E,
  input  logic             branch_taken_E,
  input  logic             md_start_D,
  input  logic             md_is_div_D,
  input  logic             md_read_D,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_Ex_flush,
  output logic             md_issue,
  output logic             md_busy,
  output logic             md_done
);

  hazard_t haz;

  // Register $0 is hard-wired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    haz.lu     = RegWr_E && MemtoReg_E && (RegWrDst_E != '0) &&
                 ((use_rs_D && (Rs_D == RegWrDst_E)) ||
                  (use_rt_D && (Rt_D == RegWrDst_E)));
    haz.md_haz = md_busy && (md_start_D || md_read_D);
    // A taken branch discards the ID instruction, so it overrides any stall.
    haz.stall  = !branch_taken_E && (haz.lu || haz.md_haz);
  end

  always_comb begin
    PC_stall    = haz.stall;
    IF_ID_stall = haz.stall;
    IF_ID_flush = branch_taken_E;
    ID_Ex_flush = branch_taken_E || haz.stall;
    md_issue    = md_start_D && !haz.stall && !branch_taken_E;
  end

`ifdef HAZARD_CTRL_MD_EN
  md_sched #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_sched (
    .clk    (clk),
    .rst_n  (rst_n),
    .issue  (md_issue),
    .is_div (md_is_div_D),
    .busy   (md_busy),
    .done   (md_done)
  );
`else
  // Without the scheduler the unit is never occupied; clock, reset and the
  // divide select have no consumer in this build.
  logic [2:0] unused_md;
  assign unused_md = {clk, rst_n, md_is_div_D};
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
`endif

endmodule
